// File: rtl/carry_resolve_unit_pkg.sv
// Shared definitions for the carry-save to binary resolver.
// Holds the FSM state encoding, default operand/slice widths and the
// helper that derives how many slices one resolution takes.
package cru_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of SLICE-bit steps needed to cover the WIDTH+2 bit result.
    function automatic int nslice(input int width, input int slice);
        return (width + 2 + slice - 1) / slice;
    endfunction

endpackage

// File: rtl/carry_resolve_unit_if.sv
// Handshake bundle for the carry resolver: a valid/ready input channel
// carrying the carry-save pair and a valid/ready output channel carrying
// the resolved WIDTH+2 bit value. master = producer/consumer side, slave = unit.
interface carry_resolve_unit_if
    import cru_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_sum;
    logic [WIDTH-1:0]   in_carry;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH+1:0]   out_value;

    modport master (
        output in_valid, in_sum, in_carry, out_ready,
        input  in_ready, out_valid, out_value
    );

    modport slave (
        input  in_valid, in_sum, in_carry, out_ready,
        output in_ready, out_valid, out_value
    );
endinterface

// File: rtl/carry_resolve_unit_rca_slice.sv
// Combinational SLICE-bit ripple-carry adder.
// Ports: a, b (SLICE bits), cin -> s (SLICE bits), cout. Zero latency.
// No flow control; pure function of its inputs.
module rca_slice
    import cru_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/carry_resolve_unit.sv
// Resolves a carry-save pair (sum, carry) into binary, SLICE bits per cycle.
// Latency: out_valid rises NSLICE cycles after the accept edge; II = NSLICE+2.
// Backpressure: one transaction in flight; in_ready low until the result is taken.
// Ports: clk, rst_n (async active-low), bus (slave modport of carry_resolve_unit_if).
module carry_resolve_unit
    import cru_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    carry_resolve_unit_if.slave  bus
);

    localparam int OW    = WIDTH + 2;
    localparam int NSL   = nslice(WIDTH, SLICE);
    localparam int PW    = NSL * SLICE;
    localparam int LAST  = NSL - 1;
    localparam int LASTW = OW - LAST * SLICE;
    localparam int CW    = (NSL > 1) ? $clog2(NSL) : 1;

    state_t             state;
    logic [PW-1:0]      a_reg;
    logic [PW-1:0]      b_reg;
    logic [OW-1:0]      res_reg;
    logic               carry_q;
    logic [CW-1:0]      cnt;
    logic               out_vld_q;
    logic               in_rdy_q;

    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [SLICE-1:0]   s_sl;
    logic               cout;

    // Operand slice selected by the counter feeds the single shared adder.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NSL; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_reg[k*SLICE +: SLICE];
                b_sl = b_reg[k*SLICE +: SLICE];
            end
        end
    end

    rca_slice #(.SLICE(SLICE)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .s    (s_sl),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg    <= PW'(bus.in_sum);
                        // Carry vector carries weight 2^(i+1): shift in a zero LSB.
                        b_reg    <= PW'({bus.in_carry, 1'b0});
                        res_reg  <= '0;
                        carry_q  <= 1'b0;
                        cnt      <= '0;
                        in_rdy_q <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry_q <= cout;
                    cnt     <= cnt + 1'b1;
                    for (int k = 0; k < LAST; k++) begin
                        if (cnt == CW'(k)) begin
                            res_reg[k*SLICE +: SLICE] <= s_sl;
                        end
                    end
                    // Last slice: only the bits that fit in the result are kept;
                    // padding sum bits and the final carry-out are dropped.
                    if (cnt == CW'(LAST)) begin
                        res_reg[OW-1:LAST*SLICE] <= s_sl[LASTW-1:0];
                        out_vld_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_rdy_q;
    assign bus.out_valid = out_vld_q;
    // Result register holds partial sums while running; expose it only when valid.
    assign bus.out_value = out_vld_q ? res_reg : '0;

endmodule

// File: tb/tb_carry_resolve_unit.sv
// Self-checking bench for carry_resolve_unit (WIDTH=16, SLICE=4).
// A transaction-level model predicts in_ready/out_valid/out_value every cycle;
// directed transactions additionally check hand-computed literal results.
module tb_carry_resolve_unit;

    localparam int WIDTH = 16;
    localparam int NSL   = 5;

    logic clk;
    logic rst_n;

    carry_resolve_unit_if #(.WIDTH(WIDTH)) bus ();

    carry_resolve_unit #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run;
    int tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy;
    int          m_cyc;
    logic [17:0] m_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_cyc  = 0;
            m_val  = '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1'b1;
                m_cyc  = 0;
                m_val  = 18'(bus.in_sum) + (18'(bus.in_carry) << 1);
            end
        end else if (m_cyc == NSL) begin
            if (bus.out_ready) m_busy = 1'b0;
        end else begin
            m_cyc++;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic m_ov;
        m_ov = m_busy && (m_cyc == NSL);
        check("cyc_in_ready",  32'(bus.in_ready),  32'(!m_busy));
        check("cyc_out_valid", 32'(bus.out_valid), 32'(m_ov));
        check("cyc_out_value", 32'(bus.out_value), m_ov ? 32'(m_val) : 32'd0);
    end

    // ---------------- directed transactions ----------------
    task automatic do_txn(input logic [15:0] s, input logic [15:0] c, input logic [17:0] lit,
                          input int hold, input bit keep, input bit imm, input string tag);
        int n;
        logic [17:0] held;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
        if (imm) check({tag, "_accept_immediate"}, 32'(n), 32'd0);
        bus.in_valid  = 1'b1;
        bus.in_sum    = s;
        bus.in_carry  = c;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_value"}, 32'(bus.out_value), 32'(lit));
        held = bus.out_value;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_sum   = ~s;
            bus.in_carry = ~c;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_value"}, 32'(bus.out_value), 32'(held));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = keep;
        check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        if (!keep) check({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_value", 32'(bus.out_value), 32'd0);
        rst_n = 1'b1;

        do_txn(16'h0000, 16'h0000, 18'h00000, 0, 1'b0, 1'b0, "zero");
        do_txn(16'hFFFF, 16'hFFFF, 18'h2FFFD, 0, 1'b0, 1'b0, "max");
        do_txn(16'h1234, 16'h0F0F, 18'h03052, 0, 1'b0, 1'b0, "mixed");
        do_txn(16'h00AB, 16'h0055, 18'h00155, 3, 1'b0, 1'b0, "hold");

        // Abort a transaction while the slice counter sits at 2.
        bus.in_valid = 1'b1;
        bus.in_sum   = 16'hFFFF;
        bus.in_carry = 16'hFFFF;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_value", 32'(bus.out_value), 32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn(16'h0FF0, 16'h0101, 18'h011F2, 0, 1'b0, 1'b1, "after_rst");

        do_txn(16'h0001, 16'h0001, 18'h00003, 0, 1'b1, 1'b0, "b2b_first");
        do_txn(16'h8000, 16'h8000, 18'h18000, 0, 1'b0, 1'b1, "b2b_second");

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
